// File: rtl/full_adder_core.sv
// Registered ripple-carry full adder: {carry,sum} = a + b + cin, one cycle latency.
// Define FULL_ADDER_OVF_EN to add a registered two's-complement overflow output.
module full_adder_core #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef FULL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             zero
);

  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             c_run;
`ifdef FULL_ADDER_OVF_EN
  logic             c_msb_in;
`endif

  // Explicit per-bit cells so every carry is a distinct gate-level term.
  always_comb begin
    add_sum = '0;
    c_run   = cin;
`ifdef FULL_ADDER_OVF_EN
    c_msb_in = cin;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = a[i] ^ b[i] ^ c_run;
`ifdef FULL_ADDER_OVF_EN
      c_msb_in = c_run;
`endif
      c_run = (a[i] & b[i]) | (a[i] & c_run) | (b[i] & c_run);
    end
    add_carry = c_run;
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             zero_d, zero_q;
`ifdef FULL_ADDER_OVF_EN
  logic             overflow_d, overflow_q;
`endif

  // Results only load under in_valid, so X on idle operands never reaches the flops.
  always_comb begin
    out_valid_d = in_valid;
    sum_d       = sum_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
`ifdef FULL_ADDER_OVF_EN
    overflow_d  = overflow_q;
`endif
    if (in_valid) begin
      sum_d      = add_sum;
      carry_d    = add_carry;
      zero_d     = (add_sum == '0);
`ifdef FULL_ADDER_OVF_EN
      overflow_d = add_carry ^ c_msb_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
`ifdef FULL_ADDER_OVF_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
`ifdef FULL_ADDER_OVF_EN
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_full_adder_core.sv
// Directed bench for full_adder_core at WIDTH=1 and WIDTH=8, with hand-computed results.
module tb_full_adder_core;

  logic       clk;
  logic       rst_n;

  logic       v1, a1, b1, cin1;
  logic       ov1, s1, c1, z1;
  logic       v8, cin8;
  logic [7:0] a8, b8;
  logic       ov8, c8, z8;
  logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
  logic       of1, of8;
`endif

  int n_checks = 0;
  int n_errors = 0;

  full_adder_core #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .sum(s1), .carry(c1),
`ifdef FULL_ADDER_OVF_EN
    .overflow(of1),
`endif
    .zero(z1)
  );

  full_adder_core #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .sum(s8), .carry(c8),
`ifdef FULL_ADDER_OVF_EN
    .overflow(of8),
`endif
    .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one WIDTH=8 operation, then check the registered result after the edge.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] es, input logic ec, input logic ez, input logic eo);
    v8 = 1'b1; a8 = a; b8 = b; cin8 = ci;
    step();
    check_eq({tag, ".valid"}, {63'd0, ov8}, 64'd1);
    check_eq({tag, ".sum"},   {56'd0, s8},  {56'd0, es});
    check_eq({tag, ".carry"}, {63'd0, c8},  {63'd0, ec});
    check_eq({tag, ".zero"},  {63'd0, z8},  {63'd0, ez});
`ifdef FULL_ADDER_OVF_EN
    check_eq({tag, ".ovf"},   {63'd0, of8}, {63'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected X overflow expectation in %s", tag);
`endif
  endtask

  logic [1:0] exp_cs1 [8];
  logic       exp_of1 [8];
  logic [2:0] abc;

  initial begin
    exp_cs1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    exp_of1 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    check_eq("rst.valid1", {63'd0, ov1}, 64'd0);
    check_eq("rst.cs1",    {62'd0, c1, s1}, 64'd0);
    check_eq("rst.zero1",  {63'd0, z1}, 64'd0);
    check_eq("rst.valid8", {63'd0, ov8}, 64'd0);
    check_eq("rst.sum8",   {56'd0, s8}, 64'd0);
    check_eq("rst.cz8",    {62'd0, c8, z8}, 64'd0);
    rst_n = 1'b1;

    // Exhaustive 1-bit truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      abc = i[2:0];
      v1 = 1'b1; a1 = abc[2]; b1 = abc[1]; cin1 = abc[0];
      step();
      check_eq($sformatf("w1.cs%0d", i), {62'd0, c1, s1}, {62'd0, exp_cs1[i]});
      check_eq($sformatf("w1.valid%0d", i), {63'd0, ov1}, 64'd1);
      check_eq($sformatf("w1.zero%0d", i), {63'd0, z1}, {63'd0, ~exp_cs1[i][0]});
`ifdef FULL_ADDER_OVF_EN
      check_eq($sformatf("w1.ovf%0d", i), {63'd0, of1}, {63'd0, exp_of1[i]});
`endif
    end

    // Asynchronous reset between edges after the 11 result.
    v1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.cs1",    {62'd0, c1, s1}, 64'd0);
    check_eq("arst.valid1", {63'd0, ov1}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("arst.idle_valid1", {63'd0, ov1}, 64'd0);
    check_eq("arst.idle_cs1",    {62'd0, c1, s1}, 64'd0);

    // Wrap cases.
    op8("wrap0", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    op8("wrap1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Hold through idle cycles with X operands.
    op8("hold", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
    v8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 1'bx;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("idle%0d.valid", i), {63'd0, ov8}, 64'd0);
      check_eq($sformatf("idle%0d.sum", i),   {56'd0, s8}, 64'd7);
      check_eq($sformatf("idle%0d.cz", i),    {62'd0, c8, z8}, 64'd0);
`ifdef FULL_ADDER_OVF_EN
      check_eq($sformatf("idle%0d.ovf", i),   {63'd0, of8}, 64'd0);
`endif
    end

    // Back-to-back valids, also exercising signed overflow.
    op8("b2b0", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    op8("b2b1", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    op8("b2b2", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    op8("b2b3", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    v8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    step();
    check_eq("end.valid8", {63'd0, ov8}, 64'd0);
    check_eq("end.sum8",   {56'd0, s8}, 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
